tt_serial_reporter: RTL
=======================

// Module: tt_serial_reporter
// PURPOSE
//  Serial output path for the tt_um_felixfeierabend tile. The testbench writes
//  stimulus into ui_in; this block carries results back out. It takes 8-bit
//  result bytes (e.g. uo_out snapshots) through a valid/ready handshake and
//  buffers them in a small FIFO. It sends them on one uio pin as UART-style
//  8N1 frames, so bench or board logic can read results with a single wire.
// PARAMETERS
//  CLK_DIV     4   clk cycles per serial bit; legal range >= 2
//  FIFO_DEPTH  4   entries; must be a power of 2, >= 2
// PORTS
//  clk         in   1  sole clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  ena         in   1  tile enable; low blocks acceptance and new frames
//  data_in     in   8  byte to transmit
//  data_valid  in   1  data_in is valid this cycle
//  data_ready  out  1  block accepts data_in this cycle
//  tx          out  1  serial line; idles high
//  busy        out  1  frame in progress OR FIFO not empty
//  overflow    out  1  sticky: valid presented while FIFO full
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries occupied
// BEHAVIOUR
//  Reset (async, any time, including mid-frame): tx=1, data_ready=0 while
//   rst_n is low, busy=0, overflow=0, fifo_level=0, FSM=IDLE. A partial frame
//   is abandoned and the line returns high immediately.
//  Handshake: data_ready = ena & ~full, computed from registered state only.
//   A push happens on the edge where data_valid & data_ready are both high.
//   data_valid & ~data_ready & ena & full sets overflow; that byte is dropped.
//  FSM states: IDLE -> START -> DATA(8 bits, LSB first) [-> PARITY] -> STOP
//   -> IDLE.
//   IDLE: tx=1. On an edge where ena & ~empty: pop the head into the shift
//    register, go to START, and load bit_cnt=0 and div_cnt=CLK_DIV-1.
//   Every state lasts exactly CLK_DIV cycles (div_cnt counts down to 0).
//   START tx=0; DATA tx=shift[0], shifting right each bit; STOP tx=1.
//   From STOP, if ena & ~empty: go straight to START on the same edge as the
//    STOP period ends (back-to-back frames, no idle gap). Otherwise go to IDLE.
//  Latency: a byte pushed into an empty FIFO in IDLE at edge N is popped at
//   edge N+1. tx falls at edge N+1.
//  Simultaneous push and pop: both occur, and fifo_level is unchanged. When the
//   FIFO is full, the same-cycle pop does not enable a push, because ready was
//   computed from the registered full flag.
//  ena deassertion: a frame already started completes. No new pop occurs.
//   Stored bytes are held.
//  FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide. Full and empty are decided
//   by the MSB compare; pointers wrap naturally.
// CONFIGURATION
//  TT_SERIAL_PARITY_EN defined: a PARITY state follows DATA, with
//   tx = ^byte (even parity) for CLK_DIV cycles. Frame = 11 bit periods.
//  Undefined: no PARITY state. Frame = 10 bit periods (8N1).
// STRUCTURE
//  Package tt_serial_pkg: FSM state encoding constants (IDLE, START, DATA,
//   PARITY, STOP) and the frame length constants FRAME_BITS_8N1=10 and
//   FRAME_BITS_8E1=11.
//  Sub-module tt_serial_fifo (sync FIFO, DEPTH, 8-bit): push, pop, dout, full,
//   empty, level.
//  The top holds the FSM, divider, shift register, overflow flag and ports.
// TESTING (CLK_DIV=4, FIFO_DEPTH=4)
//  1. Push 8'hA5 once with ena=1. Expect: tx low 4 cycles, then bits
//     1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles. busy
//     falls after the stop bit. Total 40 cycles.
//  2. Push 5 bytes back-to-back (0x01..0x05) while idle. Expect all 5 accepted:
//     the first is popped immediately, the next 4 fill the FIFO. A 6th push is
//     refused, with data_ready=0 and overflow=1 (sticky). Frames go out
//     back-to-back with no idle gap between stop and start.
//  3. Assert rst_n=0 during data bit 3 of a frame. Expect: tx=1, fifo_level=0
//     and overflow=0 immediately, without waiting for a clk edge. After
//     release, the next push transmits cleanly.
//  4. Queue 3 bytes, then drop ena mid-frame 1. Expect: frame 1 completes, tx
//     stays high, fifo_level=2 and data_ready=0. Raise ena: the remaining 2
//     frames go out in order.
//  5. Build with TT_SERIAL_PARITY_EN and push 8'h07. Expect the parity bit to
//     be 1 and the frame to last 44 cycles. Push 8'h03: parity bit 0.
//  6. With the FIFO full during a pop edge, hold data_valid. Expect no push on
//     that edge. The push happens on the next edge, with fifo_level back at 4.

Source files
------------

// File: rtl/tt_serial_pkg.sv
// Shared definitions for the tt_serial_reporter output path: FSM state
// encoding, frame length constants and the parity helper.
// Optional feature macro: TT_SERIAL_PARITY_EN (adds an even-parity bit).
package tt_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

`ifdef TT_SERIAL_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tt_serial_fifo.sv
// Small synchronous byte FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart by the MSB compare; level is the pointer
// difference. Pushes while full and pops while empty are ignored.
module tt_serial_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    import tt_serial_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop; they wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/tt_serial_reporter.sv
// Serial result reporter: bytes arrive on a valid/ready port, are buffered
// in tt_serial_fifo and leave on tx as UART-style frames (start, 8 data bits
// LSB first, optional even parity, stop). tx is registered and idles high.
// Optional feature macro: TT_SERIAL_PARITY_EN.
//
// Handshake: a byte moves on a rising clk edge where data_valid and
// data_ready are both high. data_ready depends only on ena, rst_n and the
// registered FIFO full flag, never on data_valid; a producer may hold
// data_valid until it sees data_ready. Valid while full drops the byte and
// sets the sticky overflow flag.
module tt_serial_reporter #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import tt_serial_pkg::*;

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    tx_state_e      state_q, state_d;
    logic [DW-1:0]  div_cnt_q, div_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           overflow_q, overflow_d;
`ifdef TT_SERIAL_PARITY_EN
    logic           parity_q, parity_d;
`endif

    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic           push, pop;
    logic           div_done;
    logic           start_frame;

    // Ready is held low during reset so nothing is accepted before release.
    assign data_ready = rst_n & ena & ~fifo_full;
    assign push       = data_valid & data_ready;
    assign div_done   = (div_cnt_q == '0);

    tt_serial_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Frame sequencer: next state, bit timing, pop decision and next tx level.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        start_frame = 1'b0;
`ifdef TT_SERIAL_PARITY_EN
        parity_d    = parity_q;
`endif

        if (state_q != ST_IDLE) begin
            div_cnt_d = div_done ? DIV_LOAD : div_cnt_q - DW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                start_frame = ena && !fifo_empty;
            end
            ST_START: begin
                if (div_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (div_done) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef TT_SERIAL_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_PARITY: begin
                if (div_done) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (div_done) begin
                    // Back-to-back frames: restart immediately when work waits.
                    if (ena && !fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d   = ST_START;
            shift_d   = fifo_dout;
            bit_cnt_d = 3'd0;
            div_cnt_d = DIV_LOAD;
`ifdef TT_SERIAL_PARITY_EN
            parity_d  = even_parity(fifo_dout);
`endif
        end
        pop = start_frame;

        // tx is registered, so it reflects the state being entered.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef TT_SERIAL_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase

        overflow_d = overflow_q | (data_valid & ena & fifo_full);
    end

    // Sequencer and flag registers; reset abandons any frame, tx goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef TT_SERIAL_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef TT_SERIAL_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
